// File: rtl/cmd_sched_if.sv
// Handshake bundle between UART_wrapper, cmd_sched and cmd_proc.
// The master modport is the environment side (UART, cmd_proc, host control);
// the slave modport is the scheduler itself.
interface cmd_sched_if #(
    parameter int DEPTH = 4
) ();
    logic [15:0]              in_cmd;
    logic                     in_rdy;
    logic                     in_clr;
    logic [15:0]              out_cmd;
    logic                     out_rdy;
    logic                     out_clr;
    logic                     abort;
    logic [$clog2(DEPTH):0]   count;
    logic                     dropped;

    modport master (
        output in_cmd, in_rdy, out_clr, abort,
        input  in_clr, out_cmd, out_rdy, count, dropped
    );

    modport slave (
        input  in_cmd, in_rdy, out_clr, abort,
        output in_clr, out_cmd, out_rdy, count, dropped
    );
endinterface

// File: rtl/cmd_sched.sv
// Command scheduler: buffers UART command words in a small FIFO and presents
// the head word to cmd_proc with the cmd/cmd_rdy/clr_cmd_rdy handshake.
// A UART word stalled behind a full FIFO for STALL_MAX cycles is dropped.
//
//   state   | meaning
//   --------+------------------------------------------
//   S_EMPTY | no entries, out_rdy low
//   S_VALID | 0 < count < DEPTH, head word presented
//   S_FULL  | count == DEPTH, new UART words held off
module cmd_sched #(
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 1024
) (
    input logic         clk,
    input logic         rst_n,
    cmd_sched_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STALL_MAX);

    typedef enum logic [1:0] {S_EMPTY, S_VALID, S_FULL} state_t;

    state_t             r_state;
    logic [15:0]        r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [SW-1:0]      r_stall_cnt;
    logic [15:0]        r_out_cmd;
    logic               r_out_rdy;
    logic               r_dropped;

    logic               w_full;
    logic               w_push;
    logic               w_stall;
    logic               w_stall_tc;
    logic               w_pop;
    logic [PW-1:0]      w_wr_next;
    logic [PW-1:0]      w_rd_next;
    logic [CW-1:0]      w_count_next;
    logic [15:0]        w_head_next;

    // Full is judged on the pre-pop state, so a pop and a stalled push in the
    // same cycle resolve as pop now, push on the following cycle.
    assign w_full       = (r_state == S_FULL);
    assign w_push       = bus.in_rdy & ~w_full & ~bus.abort;
    assign w_stall      = bus.in_rdy & w_full & ~bus.abort;
    assign w_stall_tc   = w_stall & (r_stall_cnt == SW'(STALL_MAX - 1));
    assign w_pop        = bus.out_clr & r_out_rdy & ~bus.abort;
    assign w_wr_next    = r_wr_ptr + PW'(w_push);
    assign w_rd_next    = r_rd_ptr + PW'(w_pop);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // The next head bypasses the memory when it is the word being written now
    // (push into empty, or push+pop with a single entry held).
    assign w_head_next  = (w_push && (r_wr_ptr == w_rd_next)) ? bus.in_cmd
                                                              : r_mem[w_rd_next];

    // Accepted, dropped-by-timeout and aborted words all release the UART.
    assign bus.in_clr   = w_push | w_stall_tc | (bus.abort & bus.in_rdy);
    assign bus.out_cmd  = r_out_cmd;
    assign bus.out_rdy  = r_out_rdy;
    assign bus.count    = r_count;
    assign bus.dropped  = r_dropped;

    // Storage write on accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_cmd;
        end
    end

    // Queue control FSM with pointers, occupancy, stall timer and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_stall_cnt <= '0;
            r_out_cmd   <= '0;
            r_out_rdy   <= 1'b0;
            r_dropped   <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= S_EMPTY;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_stall_cnt <= '0;
            r_out_rdy   <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_next;
            r_rd_ptr  <= w_rd_next;
            r_count   <= w_count_next;
            r_out_rdy <= (w_count_next != '0);
            if (w_count_next != '0) begin
                r_out_cmd <= w_head_next;
            end

            if (!w_stall || w_stall_tc) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + SW'(1);
            end
            if (w_stall_tc) begin
                r_dropped <= 1'b1;
            end

            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (w_push && !w_pop && (r_count == CW'(DEPTH - 1))) begin
                        r_state <= S_FULL;
                    end else if (w_pop && !w_push && (r_count == CW'(1))) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_state <= S_VALID;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_sched.sv
// Self-checking bench for cmd_sched: a queue scoreboard holds the words the
// bench expects to be queued; heads are compared as they are popped.
module tb_cmd_sched;
    localparam int DEPTH = 4;
    localparam int STALL = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [15:0] sb[$];

    cmd_sched_if #(.DEPTH(DEPTH)) bus ();

    cmd_sched #(.DEPTH(DEPTH), .STALL_MAX(STALL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] w);
        bus.in_cmd = w;
        bus.in_rdy = 1'b1;
        #1;
        check("push_in_clr", 32'(bus.in_clr), 32'd1);
        sb.push_back(w);
        tick();
        bus.in_rdy = 1'b0;
        #1;
        check("push_in_clr_off", 32'(bus.in_clr), 32'd0);
        check("push_count", 32'(bus.count), 32'(sb.size()));
        check("push_out_rdy", 32'(bus.out_rdy), 32'd1);
        check("push_head", 32'(bus.out_cmd), 32'(sb[0]));
    endtask

    task automatic pop_word();
        check("pop_out_rdy", 32'(bus.out_rdy), 32'd1);
        if (sb.size() != 0) begin
            check("pop_head", 32'(bus.out_cmd), 32'(sb[0]));
            void'(sb.pop_front());
        end
        bus.out_clr = 1'b1;
        tick();
        bus.out_clr = 1'b0;
        #1;
        check("pop_count", 32'(bus.count), 32'(sb.size()));
        check("pop_out_rdy_after", 32'(bus.out_rdy), 32'(sb.size() != 0));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.in_cmd  = '0;
        bus.in_rdy  = 1'b0;
        bus.out_clr = 1'b0;
        bus.abort   = 1'b0;
        tick();
        tick();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_out_rdy", 32'(bus.out_rdy), 32'd0);
        check("rst_out_cmd", 32'(bus.out_cmd), 32'd0);
        check("rst_dropped", 32'(bus.dropped), 32'd0);
        rst_n = 1'b1;
        tick();

        // single word, latency one clock
        push_word(16'h00A5);
        pop_word();

        // fill, confirm full blocks, drain in order
        for (int i = 0; i < DEPTH; i++) push_word(16'h1100 * 16'(i + 1));
        bus.in_cmd = 16'h5555;
        bus.in_rdy = 1'b1;
        #1;
        check("full_blocks_clr", 32'(bus.in_clr), 32'd0);
        bus.in_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) pop_word();

        // stall timeout drops exactly one word on the last cycle
        for (int i = 0; i < DEPTH; i++) push_word(16'h3000 + 16'(i));
        bus.in_cmd = 16'hDEAD;
        bus.in_rdy = 1'b1;
        for (int i = 0; i < STALL; i++) begin
            #1;
            check("stall_in_clr", 32'(bus.in_clr), 32'(i == STALL - 1));
            tick();
        end
        bus.in_rdy = 1'b0;
        #1;
        check("stall_dropped", 32'(bus.dropped), 32'd1);
        check("stall_count", 32'(bus.count), 32'(DEPTH));
        check("stall_head", 32'(bus.out_cmd), 32'(sb[0]));

        // pop while full with a waiting word: accepted one cycle later
        bus.in_cmd  = 16'hBEEF;
        bus.in_rdy  = 1'b1;
        bus.out_clr = 1'b1;
        #1;
        check("popfull_clr_blocked", 32'(bus.in_clr), 32'd0);
        check("popfull_head", 32'(bus.out_cmd), 32'(sb[0]));
        void'(sb.pop_front());
        tick();
        bus.out_clr = 1'b0;
        #1;
        check("popfull_clr_accept", 32'(bus.in_clr), 32'd1);
        sb.push_back(16'hBEEF);
        tick();
        bus.in_rdy = 1'b0;
        #1;
        check("popfull_count", 32'(bus.count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) pop_word();

        // simultaneous push+pop at count 2, wrapping pointers several times
        push_word(16'h4100);
        push_word(16'h4101);
        for (int i = 0; i < 14; i++) begin
            bus.in_cmd  = 16'h4200 + 16'(i);
            bus.in_rdy  = 1'b1;
            bus.out_clr = 1'b1;
            #1;
            check("pp_in_clr", 32'(bus.in_clr), 32'd1);
            check("pp_head", 32'(bus.out_cmd), 32'(sb[0]));
            void'(sb.pop_front());
            sb.push_back(16'h4200 + 16'(i));
            tick();
            #1;
            check("pp_count", 32'(bus.count), 32'd2);
        end
        bus.in_rdy  = 1'b0;
        bus.out_clr = 1'b0;
        pop_word();
        pop_word();

        // abort with three entries and a pending UART word
        for (int i = 0; i < 3; i++) push_word(16'h5000 + 16'(i));
        bus.in_cmd  = 16'h7777;
        bus.in_rdy  = 1'b1;
        bus.abort   = 1'b1;
        bus.out_clr = 1'b1;
        #1;
        check("abort_in_clr", 32'(bus.in_clr), 32'd1);
        tick();
        bus.abort   = 1'b0;
        bus.in_rdy  = 1'b0;
        bus.out_clr = 1'b0;
        sb.delete();
        #1;
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_out_rdy", 32'(bus.out_rdy), 32'd0);
        check("abort_dropped", 32'(bus.dropped), 32'd0);
        push_word(16'h0003);
        pop_word();

        // asynchronous reset while full and stalling
        for (int i = 0; i < DEPTH; i++) push_word(16'h6000 + 16'(i));
        bus.in_cmd = 16'h6666;
        bus.in_rdy = 1'b1;
        for (int i = 0; i < STALL + 5; i++) tick();
        check("pre_rst_dropped", 32'(bus.dropped), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_out_rdy", 32'(bus.out_rdy), 32'd0);
        check("arst_out_cmd", 32'(bus.out_cmd), 32'd0);
        check("arst_dropped", 32'(bus.dropped), 32'd0);
        bus.in_rdy = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        bus.out_clr = 1'b1;
        tick();
        bus.out_clr = 1'b0;
        #1;
        check("empty_pop_count", 32'(bus.count), 32'd0);
        check("empty_pop_out_rdy", 32'(bus.out_rdy), 32'd0);
        push_word(16'h1234);
        pop_word();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
